// File: rtl/dma_burst_engine_if.sv
// -----------------------------------------------------------------------------
// dma_burst_engine_if
// Bus bundle between the DMA burst engine, the external device, the CPU bus
// arbiter and memory.
//   master modport (the engine):
//     in : cmd, cmd_addr, cmd_len, cmd_steal  start command from the device
//          BG                                 bus grant from the CPU
//          edata                              block data for the current offset
//     out: BR                                 bus request
//          WRITE, data                        memory write strobe and data,
//                                             driven only while BG=1, else z
//          addr                               current block address
//          offset                             block index the device must present
//          interrupt                          one-cycle completion pulse
//          busy                               command in progress
//   slave modport: the same signals seen from the environment side.
// -----------------------------------------------------------------------------
interface dma_burst_engine_if #(
    parameter int WORD_SIZE = 16,
    parameter int LEN_W     = 4,
    parameter int MEM_BW    = 64
);
    logic                 cmd;
    logic [WORD_SIZE-1:0] cmd_addr;
    logic [LEN_W-1:0]     cmd_len;
    logic                 cmd_steal;
    logic                 BG;
    logic [MEM_BW-1:0]    edata;

    logic                 BR;
    logic                 WRITE;
    logic [WORD_SIZE-1:0] addr;
    logic [MEM_BW-1:0]    data;
    logic [LEN_W-1:0]     offset;
    logic                 interrupt;
    logic                 busy;

    modport master (
        input  cmd, cmd_addr, cmd_len, cmd_steal, BG, edata,
        output BR, WRITE, addr, data, offset, interrupt, busy
    );

    modport slave (
        output cmd, cmd_addr, cmd_len, cmd_steal, BG, edata,
        input  BR, WRITE, addr, data, offset, interrupt, busy
    );
endinterface

// File: rtl/dma_burst_engine.sv
// -----------------------------------------------------------------------------
// dma_burst_engine
// Multi-block DMA write engine. A start command supplies a base address, a
// block count and a transfer mode. The engine requests the memory bus (BR),
// and once granted (BG) writes one MEM_BW-wide block per MEM_DELAY granted
// cycles. Burst mode keeps the bus across blocks; cycle-stealing mode hands
// the bus back after every block and re-requests only once BG has dropped.
// A one-cycle interrupt marks completion.
// Ports:
//   CLK      clock, all state on the rising edge
//   reset_n  asynchronous active-low reset; an aborted transfer never interrupts
//   bus      dma_burst_engine_if.master (command, arbitration, memory bus)
// -----------------------------------------------------------------------------
module dma_burst_engine #(
    parameter int WORD_SIZE   = 16,
    parameter int BLOCK_WORDS = 4,
    parameter int MEM_BW      = 64,
    parameter int MEM_DELAY   = 4,
    parameter int LEN_W       = 4
) (
    input  logic                 CLK,
    input  logic                 reset_n,
    dma_burst_engine_if.master   bus
);

    localparam int CNT_W = (MEM_DELAY > 1) ? $clog2(MEM_DELAY) : 1;
    localparam logic [CNT_W-1:0]     CNT_LAST = CNT_W'(MEM_DELAY - 1);
    localparam logic [WORD_SIZE-1:0] ADDR_STEP = WORD_SIZE'(BLOCK_WORDS);

    typedef enum logic [2:0] {
        S_IDLE,
        S_REQ,
        S_XFER,
        S_STEAL,
        S_DONE
    } state_t;

    state_t               state_q;
    logic                 br_q;
    logic                 irq_q;
    logic                 busy_q;
    logic                 steal_q;
    logic [LEN_W-1:0]     offset_q;
    logic [LEN_W-1:0]     rem_q;
    logic [WORD_SIZE-1:0] addr_q;
    logic [CNT_W-1:0]     cnt_q;

    always_ff @(posedge CLK or negedge reset_n) begin
        if (!reset_n) begin
            state_q  <= S_IDLE;
            br_q     <= 1'b0;
            irq_q    <= 1'b0;
            busy_q   <= 1'b0;
            steal_q  <= 1'b0;
            offset_q <= '0;
            rem_q    <= '0;
            addr_q   <= '0;
            cnt_q    <= '0;
        end else begin
            // interrupt is asserted only on the XFER->DONE transition
            irq_q <= 1'b0;
            case (state_q)
                S_IDLE: begin
                    // a zero-length command is treated as no command at all
                    if (bus.cmd && (bus.cmd_len != '0)) begin
                        addr_q   <= bus.cmd_addr;
                        rem_q    <= bus.cmd_len;
                        steal_q  <= bus.cmd_steal;
                        offset_q <= '0;
                        br_q     <= 1'b1;
                        busy_q   <= 1'b1;
                        state_q  <= S_REQ;
                    end
                end

                S_REQ: begin
                    if (bus.BG) begin
                        cnt_q   <= '0;
                        state_q <= S_XFER;
                    end
                end

                S_XFER: begin
                    if (!bus.BG) begin
                        // grant revoked: the block restarts from scratch on regrant
                        cnt_q <= '0;
                    end else if (cnt_q == CNT_LAST) begin
                        rem_q <= rem_q - LEN_W'(1);
                        cnt_q <= '0;
                        if (rem_q == LEN_W'(1)) begin
                            br_q    <= 1'b0;
                            irq_q   <= 1'b1;
                            state_q <= S_DONE;
                        end else begin
                            addr_q   <= addr_q + ADDR_STEP;
                            offset_q <= offset_q + LEN_W'(1);
                            if (steal_q) begin
                                br_q    <= 1'b0;
                                state_q <= S_STEAL;
                            end
                        end
                    end else begin
                        cnt_q <= cnt_q + CNT_W'(1);
                    end
                end

                S_STEAL: begin
                    // hand the bus back; re-request only after the CPU has taken it
                    if (!bus.BG) begin
                        br_q    <= 1'b1;
                        state_q <= S_REQ;
                    end
                end

                S_DONE: begin
                    busy_q   <= 1'b0;
                    offset_q <= '0;
                    state_q  <= S_IDLE;
                end

                default: begin
                    state_q <= S_IDLE;
                end
            endcase
        end
    end

    assign bus.BR        = br_q;
    assign bus.interrupt = irq_q;
    assign bus.busy      = busy_q;
    assign bus.addr      = addr_q;
    assign bus.offset    = offset_q;

    // The memory bus is shared with the CPU: drive it only while granted.
    assign bus.WRITE = bus.BG ? 1'b1 : 1'bz;
    assign bus.data  = bus.BG ? bus.edata : {MEM_BW{1'bz}};

endmodule

// File: tb/tb_dma_burst_engine.sv
// -----------------------------------------------------------------------------
// tb_dma_burst_engine
// Self-checking bench for dma_burst_engine. A bench-side arbiter drives BG
// (random or scripted), a memory model captures every granted write, and a
// per-command reference predicts block addresses, data, interrupt count, BR
// drop count and latency from the command parameters.
// -----------------------------------------------------------------------------
module tb_dma_burst_engine;

    localparam int WORD_SIZE   = 16;
    localparam int BLOCK_WORDS = 4;
    localparam int MEM_BW      = 64;
    localparam int MEM_DELAY   = 4;
    localparam int LEN_W       = 4;

    logic CLK;
    logic reset_n;

    dma_burst_engine_if #(.WORD_SIZE(WORD_SIZE), .LEN_W(LEN_W), .MEM_BW(MEM_BW)) bus ();

    dma_burst_engine #(
        .WORD_SIZE  (WORD_SIZE),
        .BLOCK_WORDS(BLOCK_WORDS),
        .MEM_BW     (MEM_BW),
        .MEM_DELAY  (MEM_DELAY),
        .LEN_W      (LEN_W)
    ) dut (
        .CLK    (CLK),
        .reset_n(reset_n),
        .bus    (bus)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    int n_cmp = 0;
    int n_err = 0;
    int cyc   = 0;

    always @(posedge CLK) begin
        cyc++;
        if (cyc > 60000) begin
            $display("FAIL global_timeout: cycle %0d reached, required finish before 60000", cyc);
            $fatal(1, "bench timeout");
        end
    end

    task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", tag, act, exp, cyc);
        end
    endtask

    // ---------------- reference / environment state ----------------
    logic [31:0]          seed;
    int                   cur_len = 1;
    logic [MEM_BW-1:0]    mem [logic [WORD_SIZE-1:0]];
    logic [WORD_SIZE-1:0] trace_a [$];
    logic [LEN_W-1:0]     trace_o [$];
    int                   irq_cnt   = 0;
    int                   irq_cyc   = 0;
    int                   br_falls  = 0;
    int                   fg        = 0;
    bit                   fg_valid  = 0;
    bit                   manual    = 0;
    bit                   bg_manual = 0;
    bit                   revoke_en = 0;
    int                   drop_rel  = 0;
    logic                 br_prev   = 1'b0;
    logic                 bg_prev   = 1'b0;

    function automatic logic [MEM_BW-1:0] pat(input logic [31:0] s, input int idx);
        return {s, s ^ (32'(idx) * 32'h0101_0101)};
    endfunction

    // device presents the block selected by offset
    assign bus.edata = pat(seed, int'(bus.offset));

    // monitor + memory model + arbiter, all away from the active edge
    always @(negedge CLK) begin
        logic bg_n;
        if (reset_n) begin
            if (bus.BG) begin
                check("write_granted", bus.WRITE, 1'b1);
                check("data_granted", bus.data, bus.edata);
                mem[bus.addr] = bus.data;
                if (trace_a.size() == 0 || trace_a[$] != bus.addr) begin
                    trace_a.push_back(bus.addr);
                    trace_o.push_back(bus.offset);
                end
            end else begin
                check("write_released", 64'(bus.WRITE === 1'b1), 64'd0);
            end
            if (bus.BR && !br_prev) check("br_rise_while_bg", bg_prev, 1'b0);
            if (!bus.BR && br_prev) br_falls++;
            if (bus.interrupt) begin
                irq_cnt++;
                irq_cyc = cyc;
                check("irq_br_low", bus.BR, 1'b0);
                check("irq_busy_high", bus.busy, 1'b1);
            end
            if (bus.busy) check("offset_range", 64'(int'(bus.offset) < cur_len), 64'd1);
        end
        br_prev = bus.BR;

        if (manual) begin
            bg_n = bg_manual && bus.BR &&
                   !(drop_rel != 0 && fg_valid && (cyc + 1 == fg + drop_rel));
        end else if (!bus.BR) begin
            bg_n = 1'b0;
        end else if (!bus.BG) begin
            bg_n = ($urandom_range(0, 1) == 0);
        end else begin
            bg_n = !(revoke_en && $urandom_range(0, 7) == 0);
        end
        bus.BG = bg_n;
        bg_prev = bg_n;
        if (bg_n && bus.busy && !fg_valid) begin
            fg = cyc + 1;
            fg_valid = 1;
        end
    end

    // ---------------- stimulus helpers ----------------
    task automatic start_cmd(input logic [WORD_SIZE-1:0] a, input int n, input logic st);
        @(posedge CLK); #1;
        mem.delete();
        trace_a.delete();
        trace_o.delete();
        irq_cnt  = 0;
        br_falls = 0;
        fg_valid = 0;
        seed     = $urandom;
        cur_len  = (n == 0) ? 1 : n;
        bus.cmd       = 1'b1;
        bus.cmd_addr  = a;
        bus.cmd_len   = LEN_W'(n);
        bus.cmd_steal = st;
        @(posedge CLK); #1;
        bus.cmd = 1'b0;
    endtask

    task automatic wait_irq(input string tag);
        for (int i = 0; i < 3000 && irq_cnt == 0; i++) @(posedge CLK);
        repeat (4) @(posedge CLK);
        #1;
        check({tag, "_completed"}, 64'(irq_cnt != 0), 64'd1);
        check({tag, "_irq_count"}, 64'(irq_cnt), 64'd1);
        check({tag, "_busy_after"}, bus.busy, 1'b0);
        check({tag, "_br_after"}, bus.BR, 1'b0);
        check({tag, "_offset_after"}, 64'(bus.offset), 64'd0);
    endtask

    task automatic verify_mem(input string tag, input logic [WORD_SIZE-1:0] base, input int n);
        logic [WORD_SIZE-1:0] a;
        check({tag, "_blocks_written"}, 64'(mem.num()), 64'(n));
        for (int i = 0; i < n; i++) begin
            a = base + WORD_SIZE'(i * BLOCK_WORDS);
            check({tag, "_block_present"}, 64'(mem.exists(a)), 64'd1);
            check({tag, "_block_data"}, mem.exists(a) ? mem[a] : '0, pat(seed, i));
        end
    endtask

    // ---------------- test sequence ----------------
    initial begin
        int guard;
        reset_n       = 1'b0;
        bus.cmd       = 1'b0;
        bus.cmd_addr  = '0;
        bus.cmd_len   = '0;
        bus.cmd_steal = 1'b0;
        bus.BG        = 1'b0;
        seed          = 32'h1234_5678;
        repeat (3) @(posedge CLK);
        #1;
        check("rst_br", bus.BR, 1'b0);
        check("rst_irq", bus.interrupt, 1'b0);
        check("rst_busy", bus.busy, 1'b0);
        check("rst_offset", 64'(bus.offset), 64'd0);
        check("rst_addr", 64'(bus.addr), 64'd0);
        reset_n = 1'b1;
        repeat (2) @(posedge CLK);

        // reset in the middle of block 1 of 3
        manual = 0; revoke_en = 0;
        start_cmd(16'h1000, 3, 1'b0);
        guard = 0;
        while (bus.offset != 1 && guard < 500) begin @(posedge CLK); #1; guard++; end
        check("abort_reached_block1", 64'(bus.offset), 64'd1);
        @(posedge CLK); #2;
        reset_n = 1'b0;
        #1;
        check("abort_br", bus.BR, 1'b0);
        check("abort_irq", bus.interrupt, 1'b0);
        check("abort_busy", bus.busy, 1'b0);
        check("abort_offset", 64'(bus.offset), 64'd0);
        repeat (2) @(posedge CLK);
        #1 reset_n = 1'b1;
        repeat (3) @(posedge CLK);
        #1;
        check("abort_no_irq", 64'(irq_cnt), 64'd0);

        // burst, grant one cycle after BR, exact latency and address sequence
        manual = 1; bg_manual = 0; drop_rel = 0;
        start_cmd(16'h01f4, 3, 1'b0);
        guard = 0;
        while (!bus.BR && guard < 100) begin @(posedge CLK); #1; guard++; end
        check("burst_br_up", bus.BR, 1'b1);
        @(posedge CLK); #1;
        bg_manual = 1;
        wait_irq("burst");
        check("burst_latency", 64'(irq_cyc - fg), 64'(3 * MEM_DELAY));
        check("burst_br_drops", 64'(br_falls), 64'd1);
        check("burst_trace_len", 64'(trace_a.size()), 64'd3);
        for (int i = 0; i < 3 && i < trace_a.size(); i++) begin
            check("burst_trace_addr", 64'(trace_a[i]), 64'(16'h01f4 + 16'(4 * i)));
            check("burst_trace_offset", 64'(trace_o[i]), 64'(i));
        end
        verify_mem("burst", 16'h01f4, 3);
        bg_manual = 0;

        // grant revoked at count 2 of block 1: block 1 restarts in full
        bg_manual = 1; drop_rel = 7;
        start_cmd(16'h2000, 3, 1'b0);
        wait_irq("revoke");
        check("revoke_latency", 64'(irq_cyc - fg), 64'(3 * MEM_DELAY + 3));
        verify_mem("revoke", 16'h2000, 3);
        bg_manual = 0; drop_rel = 0;

        // cycle-stealing, same command
        manual = 0; revoke_en = 0;
        start_cmd(16'h01f4, 3, 1'b1);
        wait_irq("steal");
        check("steal_br_drops", 64'(br_falls), 64'd3);
        verify_mem("steal", 16'h01f4, 3);

        // zero-length command is ignored
        start_cmd(16'h3000, 0, 1'b0);
        repeat (10) @(posedge CLK);
        #1;
        check("len0_br", bus.BR, 1'b0);
        check("len0_busy", bus.busy, 1'b0);
        check("len0_irq", 64'(irq_cnt), 64'd0);
        check("len0_writes", 64'(mem.num()), 64'd0);

        // command while busy is ignored
        start_cmd(16'h4000, 2, 1'b0);
        repeat (2) @(posedge CLK);
        #1;
        bus.cmd = 1'b1; bus.cmd_addr = 16'h8000; bus.cmd_len = 4'd5; bus.cmd_steal = 1'b1;
        @(posedge CLK); #1;
        bus.cmd = 1'b0;
        wait_irq("busycmd");
        verify_mem("busycmd", 16'h4000, 2);

        // address wrap with random grant revocation
        revoke_en = 1;
        start_cmd(16'hfffc, 2, 1'b0);
        wait_irq("wrap");
        verify_mem("wrap", 16'hfffc, 2);

        // randomized commands
        for (int k = 0; k < 12; k++) begin
            logic [WORD_SIZE-1:0] ra;
            int                   rl;
            logic                 rs;
            ra = WORD_SIZE'($urandom);
            rl = $urandom_range(1, 7);
            rs = 1'($urandom_range(0, 1));
            revoke_en = ($urandom_range(0, 1) == 1);
            start_cmd(ra, rl, rs);
            wait_irq("rand");
            check("rand_br_drops", 64'(br_falls), 64'(rs ? rl : 1));
            verify_mem("rand", ra, rl);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
